wash_cycle_sequencer: RTL and testbench

- Consumer side of the cycle-configuration handshake.
- Accepts the one-cycle `cycle_ready` strobe together with wash/rinse/spin durations, latches them, and runs the three phases in order.
- Each phase is timed by a prescaled countdown. The block drives the motor, water valve and drain pump enables, and pulses `cycle_done` when the programme finishes.
- Sits between the cycle-configuration stage and the actuator drivers / status display.

---
 rtl/wash_cycle_sequencer.sv | 155 +++++++++++++++
 tb/tb_wash_cycle_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_cycle_sequencer.sv
// Wash/rinse/spin programme sequencer: latches durations on cycle_ready and times each phase with a prescaled countdown.
// Optional pause input and actuator freeze are compiled in with `define WASH_PAUSE_EN.
module wash_cycle_sequencer #(
    parameter int TICK_DIV = 1,
    parameter int DUR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cycle_ready,
    input  logic [DUR_W-1:0] wash_duration,
    input  logic [DUR_W-1:0] rinse_duration,
    input  logic [DUR_W-1:0] spin_duration,
    input  logic             abort,
`ifdef WASH_PAUSE_EN
    input  logic             pause,
`endif
    output logic             busy,
    output logic [1:0]       phase,
    output logic [DUR_W-1:0] remaining,
    output logic             motor_on,
    output logic             water_valve,
    output logic             drain_pump,
    output logic             cycle_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WASH,
        S_RINSE,
        S_SPIN,
        S_DONE
    } state_t;

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [DUR_W-1:0] rinse_q, rinse_d;
    logic [DUR_W-1:0] spin_q, spin_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             pause_act;
    logic             tick;
    logic             active;

`ifdef WASH_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    assign tick   = (presc_q == PRESC_MAX);
    assign active = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            rinse_q <= '0;
            spin_q  <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            rinse_q <= rinse_d;
            spin_q  <= spin_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        rinse_d = rinse_q;
        spin_d  = spin_q;
        presc_d = presc_q;

        case (state_q)
            S_IDLE: begin
                if (cycle_ready && !abort) begin
                    rinse_d = rinse_duration;
                    spin_d  = spin_duration;
                    presc_d = '0;
                    // Zero-length phases are skipped without spending a cycle.
                    if (wash_duration != '0) begin
                        state_d = S_WASH;
                        rem_d   = wash_duration;
                    end else if (rinse_duration != '0) begin
                        state_d = S_RINSE;
                        rem_d   = rinse_duration;
                    end else if (spin_duration != '0) begin
                        state_d = S_SPIN;
                        rem_d   = spin_duration;
                    end else begin
                        state_d = S_DONE;
                        rem_d   = '0;
                    end
                end
            end
            S_WASH, S_RINSE, S_SPIN: begin
                if (!pause_act) begin
                    if (tick) begin
                        presc_d = '0;
                        if (rem_q > DUR_W'(1)) begin
                            rem_d = rem_q - 1'b1;
                        end else if ((state_q == S_WASH) && (rinse_q != '0)) begin
                            state_d = S_RINSE;
                            rem_d   = rinse_q;
                        end else if ((state_q != S_SPIN) && (spin_q != '0)) begin
                            state_d = S_SPIN;
                            rem_d   = spin_q;
                        end else begin
                            state_d = S_DONE;
                            rem_d   = '0;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
                presc_d = '0;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            rem_d   = '0;
            presc_d = '0;
        end
    end

    always_comb begin
        phase = 2'b00;
        case (state_q)
            S_WASH:  phase = 2'b01;
            S_RINSE: phase = 2'b10;
            S_SPIN:  phase = 2'b11;
            default: phase = 2'b00;
        endcase
    end

    assign busy        = active || (state_q == S_DONE);
    assign remaining   = active ? rem_q : '0;
    assign motor_on    = active && !pause_act;
    assign water_valve = ((state_q == S_WASH) || (state_q == S_RINSE)) && !pause_act;
    assign drain_pump  = (state_q == S_SPIN);
    assign cycle_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: two instances (TICK_DIV 1 and 3) share stimulus and are checked
// every cycle against a timeline model derived from the phase durations.
module tb_wash_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cycle_ready;
    logic       abort;
    logic [3:0] wash_duration, rinse_duration, spin_duration;

    logic       busy1, motor_on1, water_valve1, drain_pump1, cycle_done1;
    logic [1:0] phase1;
    logic [3:0] remaining1;
    logic       busy3, motor_on3, water_valve3, drain_pump3, cycle_done3;
    logic [1:0] phase3;
    logic [3:0] remaining3;

    int tests = 0;
    int fails = 0;

    bit act[2];
    int kk[2];
    int lw[2];
    int lr[2];
    int ls[2];

    always #5 clk = ~clk;

    wash_cycle_sequencer #(.TICK_DIV(1), .DUR_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .cycle_ready(cycle_ready),
        .wash_duration(wash_duration), .rinse_duration(rinse_duration),
        .spin_duration(spin_duration), .abort(abort),
        .busy(busy1), .phase(phase1), .remaining(remaining1), .motor_on(motor_on1),
        .water_valve(water_valve1), .drain_pump(drain_pump1), .cycle_done(cycle_done1)
    );

    wash_cycle_sequencer #(.TICK_DIV(3), .DUR_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .cycle_ready(cycle_ready),
        .wash_duration(wash_duration), .rinse_duration(rinse_duration),
        .spin_duration(spin_duration), .abort(abort),
        .busy(busy3), .phase(phase3), .remaining(remaining3), .motor_on(motor_on3),
        .water_valve(water_valve3), .drain_pump(drain_pump3), .cycle_done(cycle_done3)
    );

    // Expected outputs from elapsed cycles since the accepted start.
    function automatic logic [10:0] expv(input int i);
        int td, k, w, r, s;
        logic [1:0] ph;
        logic [3:0] rem;
        logic dn;
        td  = (i == 0) ? 1 : 3;
        k   = kk[i];
        w   = lw[i];
        r   = lr[i];
        s   = ls[i];
        ph  = 2'd0;
        rem = 4'd0;
        dn  = 1'b0;
        if (!act[i]) return 11'd0;
        if (k < w * td) begin
            ph  = 2'd1;
            rem = 4'(w - k / td);
        end else if (k < (w + r) * td) begin
            ph  = 2'd2;
            rem = 4'(r - (k - w * td) / td);
        end else if (k < (w + r + s) * td) begin
            ph  = 2'd3;
            rem = 4'(s - (k - (w + r) * td) / td);
        end else begin
            dn = 1'b1;
        end
        return {1'b1, ph, rem, (ph != 2'd0), (ph == 2'd1) || (ph == 2'd2), (ph == 2'd3), dn};
    endfunction

    function automatic logic [10:0] obs(input int i);
        if (i == 0)
            return {busy1, phase1, remaining1, motor_on1, water_valve1, drain_pump1, cycle_done1};
        return {busy3, phase3, remaining3, motor_on3, water_valve3, drain_pump3, cycle_done3};
    endfunction

    task automatic check(input string tag);
        for (int i = 0; i < 2; i++) begin
            tests++;
            assert (obs(i) === expv(i))
            else begin
                fails++;
                $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs(i), expv(i));
            end
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int td;
            td = (i == 0) ? 1 : 3;
            if (abort) begin
                act[i] = 1'b0;
            end else if (act[i]) begin
                kk[i]++;
                if (kk[i] > (lw[i] + lr[i] + ls[i]) * td) act[i] = 1'b0;
            end else if (cycle_ready) begin
                act[i] = 1'b1;
                kk[i]  = 0;
                lw[i]  = int'(wash_duration);
                lr[i]  = int'(rinse_duration);
                ls[i]  = int'(spin_duration);
            end
        end
    endtask

    task automatic cyc(input logic cr, input logic ab, input logic [3:0] w, input logic [3:0] r,
                       input logic [3:0] s, input string tag);
        cycle_ready    = cr;
        abort          = ab;
        wash_duration  = w;
        rinse_duration = r;
        spin_duration  = s;
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic idle1(input string tag);
        cyc(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), tag);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((act[0] || act[1]) && n < 300) begin
            n++;
            idle1("drain");
        end
        idle1("drain_idle");
    endtask

    task automatic run_until_done(input int i, input int exp_lat, input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            n++;
            idle1(tag);
            seen = (i == 0) ? cycle_done1 : cycle_done3;
        end
        tests++;
        assert (seen && n == exp_lat)
        else begin
            fails++;
            $error("FAIL %s observed_latency=%0d seen=%0d expected_latency=%0d", tag, n, seen, exp_lat);
        end
    endtask

    initial begin
        int dones;
        reset = 1'b0;
        cycle_ready = 1'b0;
        abort = 1'b0;
        wash_duration = '0;
        rinse_duration = '0;
        spin_duration = '0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; kk[i] = 0; lw[i] = 0; lr[i] = 0; ls[i] = 0;
        end

        #1 reset = 1'b1;
        #2 check("reset_state");
        @(posedge clk);
        #1 check("reset_held");
        reset = 1'b0;
        idle1("post_reset");

        // Normal run 8/6/4: done at T+18 on TICK_DIV=1.
        cyc(1'b1, 1'b0, 4'd8, 4'd6, 4'd4, "start_864");
        run_until_done(0, 18, "lat_864_td1");
        drain();

        // 4/3/2: done at T+27 on TICK_DIV=3.
        cyc(1'b1, 1'b0, 4'd4, 4'd3, 4'd2, "start_432");
        run_until_done(1, 27, "lat_432_td3");
        drain();

        // Rinse skipped.
        cyc(1'b1, 1'b0, 4'd5, 4'd0, 4'd2, "start_502");
        run_until_done(0, 7, "lat_502_td1");
        drain();

        // All zero: DONE immediately, single pulse.
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, "start_000");
        tests++;
        assert (cycle_done1 === 1'b1 && cycle_done3 === 1'b1 && busy1 === 1'b1)
        else begin
            fails++;
            $error("FAIL zero_done observed=%b%b%b expected=111", cycle_done1, cycle_done3, busy1);
        end
        idle1("zero_after");
        tests++;
        assert (cycle_done1 === 1'b0 && busy1 === 1'b0 && cycle_done3 === 1'b0)
        else begin
            fails++;
            $error("FAIL zero_single_pulse observed=%b%b%b expected=000", cycle_done1, busy1, cycle_done3);
        end
        drain();

        // Abort on the third cycle of RINSE (elapsed 14).
        cyc(1'b1, 1'b0, 4'd12, 4'd8, 4'd6, "start_1286_abort");
        repeat (14) idle1("pre_abort");
        cyc(1'b0, 1'b1, 4'd3, 4'd3, 4'd3, "abort");
        tests++;
        assert ({busy1, motor_on1, water_valve1, drain_pump1, cycle_done1, phase1} === 7'd0)
        else begin
            fails++;
            $error("FAIL abort_outputs observed=%b expected=0000000",
                   {busy1, motor_on1, water_valve1, drain_pump1, cycle_done1, phase1});
        end
        dones = 0;
        repeat (5) begin
            idle1("post_abort");
            dones += int'(cycle_done1) + int'(cycle_done3);
        end
        tests++;
        assert (dones == 0)
        else begin
            fails++;
            $error("FAIL abort_no_done observed=%0d expected=0", dones);
        end

        // Abort coincident with cycle_ready in IDLE: no start.
        cyc(1'b1, 1'b1, 4'd5, 4'd5, 4'd5, "abort_wins");
        tests++;
        assert (busy1 === 1'b0 && busy3 === 1'b0)
        else begin
            fails++;
            $error("FAIL abort_wins observed=%b%b expected=00", busy1, busy3);
        end

        // Re-trigger during WASH is ignored.
        cyc(1'b1, 1'b0, 4'd12, 4'd8, 4'd6, "start_1286");
        idle1("retrig");
        cyc(1'b1, 1'b0, 4'd4, 4'd3, 4'd2, "retrig_pulse1");
        idle1("retrig");
        idle1("retrig");
        cyc(1'b1, 1'b0, 4'd4, 4'd3, 4'd2, "retrig_pulse2");
        run_until_done(0, 21, "lat_1286_retrig");
        drain();

        // Randomised programmes with occasional aborts and stray strobes.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom % 6) == 0, ($urandom % 60) == 0,
                4'($urandom % 7), 4'($urandom % 7), 4'($urandom % 7), "random");
        end
        drain();

        // Asynchronous reset mid-programme.
        cyc(1'b1, 1'b0, 4'd8, 4'd6, 4'd4, "start_reset");
        repeat (5) idle1("pre_reset");
        #2 reset = 1'b1;
        act[0] = 1'b0;
        act[1] = 1'b0;
        #1 check("async_reset");
        @(posedge clk);
        #1 check("reset_mid_held");
        reset = 1'b0;
        cyc(1'b1, 1'b0, 4'd1, 4'd1, 4'd1, "start_111");
        run_until_done(0, 3, "lat_111_td1");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
